yutorina_spm_loader: RTL
========================

Name: yutorina_spm_loader

Overview:
Boot-time writer for the SPM instruction port, the write-side counterpart of instruction fetch, which only reads that port.
- Receives a byte stream over a valid/ready handshake: 2-byte length header, then 32-bit words, big-endian.
- Assembles each group of 4 bytes into a word and writes it to SPM at consecutive word addresses from 0.
- Holds the CPU core in reset (cpu_hold) until the image is loaded.

Parameters:
WORD_WIDTH, 32, SPM data word width (bits); must equal 32.
ADDRESS_WIDTH, 12, SPM word-address width; capacity = 2^ADDRESS_WIDTH words.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session
byte_valid  input  1  byte_data valid this cycle
byte_data  input  8  incoming stream byte
byte_ready  output  1  loader accepts a byte this cycle
spm_address  output  ADDRESS_WIDTH  SPM word address
spm_address_strobe_  output  1  active-low SPM access strobe
spm_read_write  output  1  1 = read, 0 = write
spm_write_data  output  WORD_WIDTH  word to write
words_written  output  ADDRESS_WIDTH+1  words committed this session
busy  output  1  session in progress
done  output  1  sticky; load completed
error  output  1  sticky; header length exceeds capacity
cpu_hold  output  1  keep CPU in reset; = busy | ~done

Behaviour:
- Byte transfer occurs when byte_valid && byte_ready in the same cycle.
- Reset values:
  - spm_address_strobe_ = 1, spm_read_write = 1.
  - spm_address = 0, spm_write_data = 0, words_written = 0.
  - byte_ready = 0, busy = 0, done = 0, error = 0, cpu_hold = 1.
  - State = IDLE.
- Reset asserted mid-session returns to these values on the next edge. No partial write is ever issued: the strobe is never left low.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE:
  - start -> LEN_HI, busy = 1.
  - byte_ready = 0.
- LEN_HI / LEN_LO:
  - byte_ready = 1.
  - Accepted byte goes to length[15:8] / length[7:0].
  - After LEN_LO:
    - length == 0 -> DONE.
    - length > 2^ADDRESS_WIDTH -> ERROR.
    - otherwise -> DATA, with byte index 0 and spm_address 0.
- DATA:
  - byte_ready = 1.
  - The first accepted byte lands in bits [31:24], then [23:16], [15:8], [7:0].
  - On acceptance of the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - byte_ready = 0, spm_address_strobe_ = 0, spm_read_write = 0.
  - spm_write_data = the assembled word.
  - Latency: 4th byte accepted at edge N, strobe low during cycle N+1.
  - At end of cycle: words_written increments and spm_address increments.
  - If words_written reaches length -> DONE; else -> DATA.
  - Strobe returns to 1 and spm_read_write to 1.
- DONE:
  - done = 1, busy = 0, byte_ready = 0.
  - start -> clear done and words_written, go to LEN_HI.
- ERROR:
  - error = 1, busy = 0, done = 0, byte_ready = 0.
  - No SPM strobe is issued.
  - start -> clear error, go to LEN_HI.
- start while busy (LEN_HI..WRITE) is ignored.
- Bytes presented while byte_ready = 0 are not consumed; the source must hold them.
- spm_address wrap-around is impossible: length ≤ 2^ADDRESS_WIDTH. The final address written is length-1; the post-increment register may wrap to 0 only after the last write.
- Outside WRITE: spm_address_strobe_ = 1 and spm_read_write = 1, so the instruction port is idle.
- All outputs are registered except cpu_hold, which is combinational from busy and done.

Test Plan:
1. Basic load:
   - Stimulus: reset, start, bytes 00 02 11 22 33 44 AA BB CC DD with byte_valid held high.
   - Response: a write at address 0 of 0x11223344 one cycle after byte 0x44.
   - Response: a write at address 1 of 0xAABBCCDD.
   - Response: done = 1 and cpu_hold = 0 on the cycle after the second write; words_written = 2.
2. Empty image:
   - Stimulus: header 00 00.
   - Response: DONE the cycle after byte 2; no strobe; words_written = 0; byte_ready = 0 thereafter.
3. Oversize image:
   - Stimulus: ADDRESS_WIDTH = 12, header 10 01 (4097).
   - Response: error = 1, done = 0, cpu_hold = 1, no strobe.
   - Stimulus: start then header 00 01 plus one word.
   - Response: error clears and the load succeeds at address 0.
4. Stalled source:
   - Stimulus: byte_valid high every other cycle, same stream as test 1.
   - Response: identical writes and data.
   - Response: byte_ready = 0 during each WRITE cycle and no byte is consumed there.
5. Reset mid-load:
   - Stimulus: assert reset after header 00 02 and 2 data bytes.
   - Response: next cycle all outputs at reset values, no strobe.
   - Stimulus: restart with test 1 stream.
   - Response: writes begin at address 0 with fresh word assembly.
6. Ignored start:
   - Stimulus: start pulses during LEN_LO, DATA and WRITE.
   - Response: no state change; the session completes as in test 1.
   - Stimulus: start in DONE.
   - Response: done clears on the next cycle.

Source files
------------

// File: rtl/yutorina_spm_loader.sv
// yutorina_spm_loader
//   Boot-time writer for the SPM instruction port. It takes a byte stream
//   (2-byte big-endian length header followed by big-endian 32-bit words),
//   writes each word at consecutive word addresses from 0, and keeps the
//   CPU core held in reset until the image is fully loaded.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a session (IDLE/DONE/ERROR)
//   byte_valid/byte_data  incoming stream byte
//   byte_ready            loader consumes the byte this cycle
//   spm_address           SPM word address
//   spm_address_strobe_   active-low SPM access strobe (one cycle per word)
//   spm_read_write        1 = read (idle), 0 = write
//   spm_write_data        word being written
//   words_written         words committed this session
//   busy / done / error   session status (done, error sticky until start)
//   cpu_hold              core reset hold, busy | ~done
module yutorina_spm_loader #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic [ADDRESS_WIDTH-1:0] spm_address,
  output logic                     spm_address_strobe_,
  output logic                     spm_read_write,
  output logic [WORD_WIDTH-1:0]    spm_write_data,
  output logic [ADDRESS_WIDTH:0]   words_written,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic                     cpu_hold
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
  } state_t;

  localparam int unsigned                CAPACITY = 32'd1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0]     WW_ONE   = 1;
  localparam logic [ADDRESS_WIDTH-1:0]   ADDR_ONE = 1;

  state_t      state, state_n;
  logic [15:0] length;
  logic [1:0]  byte_idx;
  logic        take;
  logic [15:0] len_full;
  logic        oversize;
  logic        last_word;

  assign take      = byte_valid && byte_ready;
  // Full header as it will be once the low byte is taken this cycle.
  assign len_full  = {length[15:8], byte_data};
  assign oversize  = 32'(len_full) > CAPACITY;
  assign last_word = (32'(words_written) + 32'd1) == 32'(length);
  assign cpu_hold  = busy | ~done;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = LEN_HI;
      LEN_HI: if (take) state_n = LEN_LO;
      LEN_LO: if (take) begin
        if (len_full == 16'd0) state_n = DONE;
        else if (oversize)     state_n = ERROR;
        else                   state_n = DATA;
      end
      DATA:   if (take && byte_idx == 2'd3) state_n = WRITE;
      WRITE:  state_n = last_word ? DONE : DATA;
      DONE:   if (start) state_n = LEN_HI;
      ERROR:  if (start) state_n = LEN_HI;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      length              <= '0;
      byte_idx            <= '0;
      byte_ready          <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
      spm_address_strobe_ <= 1'b1;
      spm_read_write      <= 1'b1;
      spm_address         <= '0;
      spm_write_data      <= '0;
      words_written       <= '0;
    end else begin
      state <= state_n;
      // Status/strobe flops are loaded from the next state so they line up
      // exactly with the state they describe.
      byte_ready          <= (state_n == LEN_HI) || (state_n == LEN_LO) || (state_n == DATA);
      busy                <= (state_n == LEN_HI) || (state_n == LEN_LO) ||
                             (state_n == DATA)   || (state_n == WRITE);
      done                <= (state_n == DONE);
      error               <= (state_n == ERROR);
      spm_address_strobe_ <= (state_n != WRITE);
      spm_read_write      <= (state_n != WRITE);

      if (take && state == LEN_HI) length[15:8] <= byte_data;
      if (take && state == LEN_LO) begin
        length[7:0] <= byte_data;
        byte_idx    <= 2'd0;
        spm_address <= '0;
      end
      // Shift-in assembly: after four bytes the first lands in [31:24].
      if (take && state == DATA) begin
        spm_write_data <= {spm_write_data[WORD_WIDTH-9:0], byte_data};
        byte_idx       <= byte_idx + 2'd1;
      end
      // Post-increment may wrap the address only after the final write.
      if (state == WRITE) begin
        words_written <= words_written + WW_ONE;
        spm_address   <= spm_address + ADDR_ONE;
      end
      if (start && (state == IDLE || state == DONE || state == ERROR))
        words_written <= '0;
    end
  end

endmodule
